// File: rtl/idli_pkg.sv
// Shared types for the idli core: register selectors and ALU opcodes.
package idli_pkg;

  typedef logic [2:0] greg_t;

  localparam int NIB_W = 4;

  typedef enum logic [2:0] {
    ALU_OP_ADD  = 3'b000,
    ALU_OP_SUB  = 3'b001,
    ALU_OP_AND  = 3'b010,
    ALU_OP_OR   = 3'b011,
    ALU_OP_XOR  = 3'b100,
    ALU_OP_ANDN = 3'b101,
    ALU_OP_SHL  = 3'b110,
    ALU_OP_SHLC = 3'b111
  } alu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } alu_state_t;

  function automatic logic op_is_shift(alu_op_t op);
    return (op == ALU_OP_SHL) || (op == ALU_OP_SHLC);
  endfunction

  // Logical ops leave the C flag untouched.
  function automatic logic op_writes_c(alu_op_t op);
    return (op == ALU_OP_ADD) || (op == ALU_OP_SUB) || op_is_shift(op);
  endfunction

endpackage

// File: rtl/idli_alu_nib_m.sv
// Combinational 4-bit ALU slice; carry and shift chain through cin/cout and sin/sout.
module idli_alu_nib_m
  import idli_pkg::*;
(
  input  alu_op_t          op,
  input  logic [NIB_W-1:0] b,
  input  logic [NIB_W-1:0] c,
  input  logic             cin,
  input  logic             sin,
  output logic [NIB_W-1:0] result,
  output logic             cout,
  output logic             sout
);

  logic [NIB_W:0] sum;

  always_comb begin
    sum    = {1'b0, b} + {1'b0, ((op == ALU_OP_SUB) ? ~c : c)} + {{NIB_W{1'b0}}, cin};
    result = '0;
    cout   = 1'b0;
    case (op)
      ALU_OP_ADD, ALU_OP_SUB: begin
        result = sum[NIB_W-1:0];
        cout   = sum[NIB_W];
      end
      ALU_OP_AND:  result = b & c;
      ALU_OP_OR:   result = b | c;
      ALU_OP_XOR:  result = b ^ c;
      ALU_OP_ANDN: result = b & ~c;
      ALU_OP_SHL, ALU_OP_SHLC: begin
        result = {b[NIB_W-2:0], sin};
        cout   = b[NIB_W-1];
      end
      default: ;
    endcase
  end

  assign sout = b[NIB_W-1];

endmodule

// File: rtl/idli_alu_m.sv
// Nibble-serial 16-bit ALU, LSB nibble first, four cycles per word.
// IDLI_ALU_SHIFT_EN enables SHL/SHLC; without it those opcodes are reported illegal.
module idli_alu_m
  import idli_pkg::*;
(
  input  logic       i_alu_gck,
  input  logic       i_alu_rst,
  input  logic       i_alu_vld,
  input  alu_op_t    i_alu_op,
  input  greg_t      i_alu_a,
  input  logic [3:0] i_alu_b_data,
  input  logic [3:0] i_alu_c_data,
  output greg_t      o_alu_a,
  output logic       o_alu_a_vld,
  output logic [3:0] o_alu_a_data,
  output logic       o_alu_busy,
  output logic [1:0] o_alu_nib,
  output logic       o_alu_flag_z,
  output logic       o_alu_flag_c,
  output logic       o_alu_flag_n,
  output logic       o_alu_flag_vld,
  output logic       o_alu_illegal
);

  alu_state_t state_q, state_d;
  logic [1:0] nib_q;
  alu_op_t    op_q;
  greg_t      a_q;
  logic       carry_q, zero_q;
  logic       flag_z_q, flag_c_q, flag_n_q, flag_vld_q;

  logic       active, first, last, legal, cur_ill;
  alu_op_t    cur_op;
  greg_t      cur_a;
  logic       cin, sin, cout, zero_acc;
  logic [3:0] res;

`ifdef IDLI_ALU_SHIFT_EN
  logic shift_q, sout;
`else
  logic ill_q, sout_unused;
`endif

  // Nibble 0 uses the live opcode/destination so the result has zero latency.
  always_comb begin
    active = !i_alu_rst && ((state_q == ST_RUN) || i_alu_vld);
    first  = active && (nib_q == 2'd0);
    last   = active && (nib_q == 2'd3);
    cur_op = first ? i_alu_op : op_q;
    cur_a  = first ? i_alu_a : a_q;
    cin    = first ? (cur_op == ALU_OP_SUB) : carry_q;
`ifdef IDLI_ALU_SHIFT_EN
    cur_ill = 1'b0;
    sin     = first ? ((cur_op == ALU_OP_SHLC) && flag_c_q) : shift_q;
`else
    cur_ill = first ? op_is_shift(i_alu_op) : ill_q;
    sin     = 1'b0;
`endif
    legal    = active && !cur_ill;
    zero_acc = (first ? 1'b1 : zero_q) && (res == 4'd0);
  end

  idli_alu_nib_m u_nib (
    .op     (cur_op),
    .b      (i_alu_b_data),
    .c      (i_alu_c_data),
    .cin    (cin),
    .sin    (sin),
    .result (res),
    .cout   (cout),
`ifdef IDLI_ALU_SHIFT_EN
    .sout   (sout)
`else
    .sout   (sout_unused)
`endif
  );

  always_ff @(posedge i_alu_gck or posedge i_alu_rst) begin
    if (i_alu_rst) begin
      state_q <= ST_IDLE;
      nib_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      if (active) nib_q <= nib_q + 2'd1;
    end
  end

  // A new word may only begin at nibble 3; vld elsewhere in RUN is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_alu_vld) state_d = ST_RUN;
      ST_RUN:  if ((nib_q == 2'd3) && !i_alu_vld) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_alu_a_vld    = legal;
    o_alu_a_data   = legal ? res : 4'd0;
    o_alu_a        = active ? cur_a : greg_t'(3'd0);
    o_alu_busy     = (state_q == ST_RUN) && (nib_q != 2'd0);
    o_alu_nib      = nib_q;
    o_alu_illegal  = first && cur_ill;
    o_alu_flag_z   = flag_z_q;
    o_alu_flag_c   = flag_c_q;
    o_alu_flag_n   = flag_n_q;
    o_alu_flag_vld = flag_vld_q;
  end

  always_ff @(posedge i_alu_gck or posedge i_alu_rst) begin
    if (i_alu_rst) begin
      op_q       <= ALU_OP_ADD;
      a_q        <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_n_q   <= 1'b0;
      flag_vld_q <= 1'b0;
`ifdef IDLI_ALU_SHIFT_EN
      shift_q    <= 1'b0;
`else
      ill_q      <= 1'b0;
`endif
    end else begin
      flag_vld_q <= last && legal;
      if (active) begin
        if (first) begin
          op_q <= i_alu_op;
          a_q  <= i_alu_a;
`ifndef IDLI_ALU_SHIFT_EN
          ill_q <= cur_ill;
`endif
        end
        carry_q <= cout;
        zero_q  <= zero_acc;
`ifdef IDLI_ALU_SHIFT_EN
        shift_q <= sout;
`endif
        if (last && legal) begin
          flag_z_q <= zero_acc;
          flag_n_q <= res[3];
          if (op_writes_c(cur_op)) flag_c_q <= cout;
        end
      end
    end
  end

endmodule

// File: tb/tb_idli_alu_m.sv
// Scoreboard bench for idli_alu_m: driver queues expected nibbles/flags, monitor pops on outputs.
module tb_idli_alu_m;
  import idli_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  alu_op_t    op  = ALU_OP_ADD;
  greg_t      a   = 3'd0;
  logic [3:0] b   = 4'd0;
  logic [3:0] c   = 4'd0;

  greg_t      o_a;
  logic       o_a_vld, o_busy, o_z, o_c, o_n, o_flag_vld, o_illegal;
  logic [3:0] o_a_data;
  logic [1:0] o_nib;

  idli_alu_m dut (
    .i_alu_gck      (clk),
    .i_alu_rst      (rst),
    .i_alu_vld      (vld),
    .i_alu_op       (op),
    .i_alu_a        (a),
    .i_alu_b_data   (b),
    .i_alu_c_data   (c),
    .o_alu_a        (o_a),
    .o_alu_a_vld    (o_a_vld),
    .o_alu_a_data   (o_a_data),
    .o_alu_busy     (o_busy),
    .o_alu_nib      (o_nib),
    .o_alu_flag_z   (o_z),
    .o_alu_flag_c   (o_c),
    .o_alu_flag_n   (o_n),
    .o_alu_flag_vld (o_flag_vld),
    .o_alu_illegal  (o_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] data;
    greg_t      a;
    logic [1:0] nib;
    logic       busy;
  } nib_exp_t;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
  } flg_t;

  nib_exp_t nq[$];
  flg_t     fq[$];
  bit       iq[$];
  flg_t     last_f = flg_t'(3'b000);

  int applied = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    nib_exp_t e;
    flg_t     f;
    if (o_a_vld) begin
      if (nq.size() == 0) check("spurious a_vld", 16'd1, 16'd0);
      else begin
        e = nq.pop_front();
        check("nibble {data,a,nib,busy}", 16'({o_a_data, o_a, o_nib, o_busy}), 16'(e));
      end
    end
    if (o_flag_vld) begin
      if (fq.size() == 0) check("spurious flag_vld", 16'd1, 16'd0);
      else begin
        f = fq.pop_front();
        check("flags {z,c,n}", 16'({o_z, o_c, o_n}), 16'(f));
      end
    end
    if (o_illegal) begin
      if (iq.size() == 0) check("spurious illegal", 16'd1, 16'd0);
      else begin
        void'(iq.pop_front());
        check("illegal a_vld", 16'(o_a_vld), 16'd0);
      end
    end
  end

  // Opcode/destination are scrambled after nibble 0 to prove they are latched.
  task automatic run_op(input alu_op_t o, input greg_t d, input logic [15:0] bw, input logic [15:0] cw,
                        input logic [15:0] res, input flg_t f, input bit legal, input bit chain,
                        input bit ghost);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vld = (i == 0) || (ghost && (i == 1 || i == 2)) || (chain && i == 3);
      op  = (i == 0) ? o : alu_op_t'(o ^ 3'b101);
      a   = (i == 0) ? d : ~d;
      b   = bw[4*i +: 4];
      c   = cw[4*i +: 4];
      if (legal) nq.push_back('{data: res[4*i +: 4], a: d, nib: 2'(i), busy: (i != 0)});
      else begin
        if (i == 0) iq.push_back(1'b1);
        #1 check("illegal nib counter", 16'(o_nib), 16'(i));
      end
      if (legal && i == 3) begin
        fq.push_back(f);
        last_f = f;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      vld = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", 16'({o_a_vld, o_a_data, o_busy, o_nib, o_z, o_c, o_n, o_flag_vld, o_illegal, o_a}), 16'd0);
    vld = 1'b1; op = ALU_OP_OR; a = 3'd5; b = 4'hF; c = 4'hF;
    #1 check("reset gates vld", 16'({o_a_vld, o_a_data}), 16'd0);
    vld = 1'b0;
    rst = 1'b0;

    run_op(ALU_OP_ADD,  3'd1, 16'h00FF, 16'h0001, 16'h0100, flg_t'(3'b000), 1, 0, 0);
    run_op(ALU_OP_SUB,  3'd2, 16'h1234, 16'h1234, 16'h0000, flg_t'(3'b110), 1, 0, 0);
    run_op(ALU_OP_SUB,  3'd3, 16'h0000, 16'h0001, 16'hFFFF, flg_t'(3'b001), 1, 0, 0);
    run_op(ALU_OP_ADD,  3'd4, 16'h8000, 16'h8001, 16'h0001, flg_t'(3'b010), 1, 1, 0);
    run_op(ALU_OP_XOR,  3'd5, 16'hF0F0, 16'hFFFF, 16'h0F0F, flg_t'(3'b010), 1, 0, 0);
    run_op(ALU_OP_AND,  3'd6, 16'hF00F, 16'h0FF0, 16'h0000, flg_t'(3'b110), 1, 0, 0);
    run_op(ALU_OP_ANDN, 3'd0, 16'hFFFF, 16'h00FF, 16'hFF00, flg_t'(3'b011), 1, 0, 0);

`ifdef IDLI_ALU_SHIFT_EN
    run_op(ALU_OP_SHL,  3'd1, 16'h8001, 16'hABCD, 16'h0002, flg_t'(3'b010), 1, 1, 0);
    run_op(ALU_OP_SHLC, 3'd2, 16'h0000, 16'hFFFF, 16'h0001, flg_t'(3'b000), 1, 0, 0);
`else
    run_op(ALU_OP_SHL,  3'd1, 16'h8001, 16'h0000, 16'h0000, last_f, 0, 0, 0);
    idle(1);
    check("flags kept after illegal", 16'({o_z, o_c, o_n}), 16'(last_f));
    check("no flag_vld after illegal", 16'(o_flag_vld), 16'd0);
    run_op(ALU_OP_SHLC, 3'd2, 16'h0000, 16'h0000, 16'h0000, last_f, 0, 1, 0);
    run_op(ALU_OP_ADD,  3'd3, 16'h0001, 16'h0001, 16'h0002, flg_t'(3'b000), 1, 0, 0);
`endif

    run_op(ALU_OP_ADD,  3'd2, 16'h0003, 16'h0004, 16'h0007, flg_t'(3'b000), 1, 0, 1);
    idle(1);
    check("idle after ghost vld", 16'({o_a_vld, o_busy, o_nib}), 16'd0);
    run_op(ALU_OP_OR,   3'd7, 16'h8000, 16'h0001, 16'h8001, flg_t'(3'b001), 1, 0, 0);
    idle(1);

    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      vld = (i == 0); op = ALU_OP_ADD; a = 3'd6;
      b = 4'h1; c = 4'h2;
      nq.push_back('{data: 4'h3, a: 3'd6, nib: 2'(i), busy: (i != 0)});
    end
    @(posedge clk); #1;
    b = 4'h0; c = 4'h0;
    #1 check("a_vld at nibble 2", 16'({o_a_vld, o_nib}), 16'({1'b1, 2'd2}));
    rst = 1'b1;
    #1 check("async abort", 16'({o_a_vld, o_busy, o_nib, o_z, o_c, o_n}), 16'd0);
    last_f = flg_t'(3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(ALU_OP_SUB,  3'd5, 16'h0005, 16'h0005, 16'h0000, flg_t'(3'b110), 1, 0, 0);
    idle(3);

    check("nibble queue drained", 16'(nq.size()), 16'd0);
    check("flag queue drained", 16'(fq.size()), 16'd0);
    check("illegal queue drained", 16'(iq.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/idli_alu_m.md
# idli_alu_m

Nibble-serial 16-bit ALU directly downstream of the general register file. Each cycle it consumes one 4-bit nibble of the B and C operands from the register file's read ports, LSB nibble first, and returns one result nibble for write-back on the register file's A port. A full 16-bit operation takes four gated-clock cycles. Carry, shift-in and zero state are held in flops between nibbles, and Z/C/N flags are registered at word end.

## Interface
Parameters: none; widths are fixed by the package types.
- i_alu_gck  in  1  gated core clock (the same clock that drives the register file)
- i_alu_rst  in  1  asynchronous reset, active-high
- i_alu_vld  in  1  start of an operation; that cycle is nibble 0
- i_alu_op  in  3  alu_op_t opcode; sampled at nibble 0
- i_alu_a  in  3  destination greg_t; sampled at nibble 0
- i_alu_b_data  in  4  current nibble of operand B
- i_alu_c_data  in  4  current nibble of operand C
- o_alu_a  out  3  destination register, connects to the register file's a input
- o_alu_a_vld  out  1  write enable for the current result nibble
- o_alu_a_data  out  4  result nibble
- o_alu_busy  out  1  operation in progress (nibbles 1–3)
- o_alu_nib  out  2  current nibble index
- o_alu_flag_z / _c / _n  out  1 each  registered flags
- o_alu_flag_vld  out  1  one-cycle pulse when the flags update
- o_alu_illegal  out  1  one-cycle pulse when an opcode is not compiled in

## Operation
Opcodes:
- 000 ADD: b+c
- 001 SUB: b+~c+1
- 010 AND
- 011 OR
- 100 XOR
- 101 ANDN: b&~c
- 110 SHL: b<<1, C ignored
- 111 SHLC: b<<1, with the stored C flag shifted in at bit 0

State machine:
- States are IDLE and RUN. RUN holds a 2-bit nibble counter running 0→3.
- At nibble 0 the live i_alu_op and i_alu_a drive the datapath directly. Both are latched for nibbles 1–3.
- IDLE→RUN happens on i_alu_vld. RUN stays RUN while the counter is below 3.
- At nibble 3: if i_alu_vld=1, the counter wraps to 0 and the next operation starts with no bubble. Otherwise the state returns to IDLE.
- i_alu_vld during nibbles 0–2 is ignored.

Datapath per nibble:
- Arithmetic carry-in comes from the carry flop. At nibble 0 the carry-in is 0 for ADD and 1 for SUB.
- SHL/SHLC shift-in comes from the shift flop, which holds the previous nibble's b[3]. At nibble 0 the shift-in is 0 for SHL and flag_c_q for SHLC.
- The zero accumulator ANDs (result nibble == 0) across all four nibbles.

Flags, updated at the end of nibble 3:
- Z = accumulated zero.
- N = result bit 15.
- C = carry-out of bit 15 for ADD/SUB (SUB: 1 means no borrow); b[15] for SHL/SHLC; unchanged for logical ops.

Outputs:
- o_alu_a_vld is high for all four nibbles of a legal operation.
- o_alu_a_data is 0 and o_alu_a_vld is 0 while IDLE.

Arithmetic is modulo 2^16; overflow is not flagged.

## Timing
- Result nibble n is combinational from the same-cycle operand nibble n, so there is zero latency. The register file captures nibble n on the same gck edge.
- Flags are registered on the edge closing nibble 3. o_alu_flag_vld is high the following cycle.
- Reset values: state IDLE, counter 0, all flags 0, all pulses 0, and all outputs 0.
- Reset mid-operation aborts the operation at once: o_alu_a_vld falls asynchronously, flags clear, and the partial word already written is not repaired.
- Back-to-back SHLC uses flag C from the preceding word, which is registered before nibble 0 of the new word.

## Configuration
IDLI_ALU_SHIFT_EN
- Defined: SHL and SHLC are implemented, with the shift flop included.
- Undefined: opcodes 110/111 are illegal. For these opcodes:
  - o_alu_illegal pulses at nibble 0;
  - o_alu_a_vld stays 0 for the four nibbles;
  - flags are unchanged and o_alu_flag_vld does not pulse;
  - the nibble counter still runs, so the timing matches a legal op.

## Structure
- idli_pkg: alu_op_t (3-bit) and the ALU_OP_ADD…ALU_OP_SHLC constants. The existing greg_t is reused for i_alu_a/o_alu_a.
- Sub-module idli_alu_nib_m: a purely combinational 4-bit slice.
  - Inputs: op, b, c, cin, sin.
  - Outputs: result, cout, sout.
- idli_alu_m holds the state machine, the counter, the carry, shift and zero flops, and the flags.

## Test plan
- ADD 0x00FF+0x0001 (B nibbles F,F,0,0; C nibbles 1,0,0,0) → a_data 0,0,1,0, a_vld high for 4 cycles; Z=0, C=0, N=0.
- SUB 0x1234−0x1234 → nibbles 0,0,0,0; Z=1, C=1, N=0. SUB 0x0000−0x0001 → F,F,F,F; Z=0, C=0, N=1.
- ADD then XOR 0xF0F0^0xFFFF with i_alu_vld at nibble 3 → o_alu_nib goes 3→0 with no gap; XOR result 0x0F0F; flag_vld pulses twice; C unchanged by XOR.
- Macro on: SHL 0x8001 → 0x0002 with C=1; then SHLC 0x0000 → 0x0001 with C=0. Macro off: opcode 110 → illegal pulse, a_vld 0, flags unchanged.
- Assert i_alu_rst at nibble 2 of ADD → a_vld 0 immediately, flags 0, busy 0. After release, i_alu_vld starts again at nibble 0.
- i_alu_vld pulsed at nibbles 1 and 2 → ignored; the op in progress completes unchanged and the FSM returns to IDLE after nibble 3.
